dcache_fill: RTL
================

DCACHE_FILL -- requirements
Module: dcache_fill

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 64 sets, 8 ways, 64-byte lines, 8 beats of 64 bits per line, 44-bit tag entry.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 lookup2fill_valid  input  1  miss request from lookup.
REQ-005 lookup2fill_addr  input  64  miss address; bits [11:6] index, [53:12] tag, [5:0] ignored, [63:54] ignored.
REQ-006 fill2lookup_ready  output  1  high only in IDLE.
REQ-007 fill2lookup_done  output  1  one-cycle pulse when a line fill completes.
REQ-008 fill2lookup_way  output  3  way filled; valid while fill2lookup_done is high.
REQ-009 fill2mem_req_valid / mem2fill_req_ready  output / input  1 / 1  line read request handshake.
REQ-010 fill2mem_req_addr  output  64  {captured addr[63:6], 6'b0}.
REQ-011 mem2fill_resp_valid / mem2fill_resp_last  input / input  1 / 1  response beat valid; last-beat marker.
REQ-012 mem2fill_resp_data  input  64  response beat data, beat 0 first.
REQ-013 fill2mem_resp_ready  output  1  high only in RECV.
REQ-014 fill2data_array_valid  output  1  data write strobe, one per accepted beat.
REQ-015 fill2data_array_index / _way / _offset / _wdata  output  6 / 3 / 3 / 64  data write set, way, beat number, data.
REQ-016 lookup2tag_array_valid  input  1  lookup is reading the tag array this cycle.
REQ-017 fill2tag_array_valid / _index / _way / _wdata  output  1 / 6 / 3 / 44  tag write to the tag array.

Function
REQ-018 SHALL implement states IDLE, REQ, RECV, TAG, DONE.
REQ-019 IDLE: on lookup2fill_valid && fill2lookup_ready, capture addr and victim way (current round-robin counter), go to REQ.
REQ-020 REQ: fill2mem_req_valid high; address and valid held stable until mem2fill_req_ready; on handshake go to RECV.
REQ-021 RECV: each cycle with mem2fill_resp_valid && fill2mem_resp_ready, drive fill2data_array_valid combinationally that same cycle with offset = beat counter, wdata = resp_data, and increment the 3-bit beat counter.
REQ-022 RECV: accepted beat with resp_last -> TAG, regardless of beat count; beat counter returns to 0.
REQ-023 The beat counter SHALL wrap 7->0 without error if more than 8 beats arrive before resp_last; data writes continue at wrapped offsets.
REQ-024 TAG: fill2tag_array_valid = !lookup2tag_array_valid; wdata = {1'b1 valid, 1'b0 dirty, tag[53:12]}; while lookup2tag_array_valid is high, hold in TAG with no write; on the first cycle it is low, write and go to DONE.
REQ-025 fill2tag_array_valid and lookup2tag_array_valid SHALL never be high in the same cycle.
REQ-026 DONE: fill2lookup_done = 1 and fill2lookup_way = victim for exactly one cycle; victim counter increments mod 8 (7->0); go to IDLE.
REQ-027 Index and way outputs for data and tag SHALL equal the captured index and victim throughout a fill.
REQ-028 A new request SHALL NOT be accepted in DONE; the earliest acceptance is the cycle after DONE.
REQ-029 Minimum latency, acceptance to done pulse: 1 (REQ, ready=1) + 8 (RECV) + 1 (TAG) = done on the 11th cycle after the acceptance cycle.
REQ-030 Strobe outputs (all *_valid, fill2lookup_done) SHALL be low in any state not listed for them.

Reset
REQ-031 On reset: state IDLE, beat counter 0, victim counter 0, captured address 0; fill2lookup_ready = 1; all other outputs 0.
REQ-032 Reset asserted mid-fill SHALL abandon the fill with no further data or tag writes; it SHALL NOT pulse done.

Verification
REQ-033 Basic fill: addr 0x0000_0000_0001_2340, req_ready = 1, 8 back-to-back beats with last on beat 7 -> 8 data writes at index 0x0D, way 0, offsets 0..7; tag write wdata = {1,0,42'h12}; done pulse with way 0 on the 11th cycle after acceptance.
REQ-034 Round robin: 9 consecutive fills -> ways 0,1,...,7,0.
REQ-035 Backpressure: req_ready low for 5 cycles, then resp_valid gaps between beats -> request address held stable; data writes only on beat cycles; offsets remain contiguous.
REQ-036 Tag conflict: lookup2tag_array_valid high for 3 cycles on TAG entry -> no tag write for those 3 cycles; write on the 4th cycle; never overlaps the lookup read.
REQ-037 Short or long burst: last on beat 3 -> TAG after 4 writes; 10 beats with last on beat 9 -> offsets 0..7,0,1, then TAG.
REQ-038 Reset during RECV after 4 beats -> outputs at reset values immediately; no done pulse; the next fill uses way 0.

Source files
------------

// File: rtl/dcache_fill.sv
// rtl/dcache_fill.sv - data cache line fill engine
// Fetches a 64-byte line on a miss, streams its beats into the data array, then installs the tag.
module dcache_fill (
  input  logic        clock,
  input  logic        reset,
  input  logic        lookup2fill_valid,
  input  logic [63:0] lookup2fill_addr,
  output logic        fill2lookup_ready,
  output logic        fill2lookup_done,
  output logic [2:0]  fill2lookup_way,
  output logic        fill2mem_req_valid,
  input  logic        mem2fill_req_ready,
  output logic [63:0] fill2mem_req_addr,
  input  logic        mem2fill_resp_valid,
  input  logic        mem2fill_resp_last,
  input  logic [63:0] mem2fill_resp_data,
  output logic        fill2mem_resp_ready,
  output logic        fill2data_array_valid,
  output logic [5:0]  fill2data_array_index,
  output logic [2:0]  fill2data_array_way,
  output logic [2:0]  fill2data_array_offset,
  output logic [63:0] fill2data_array_wdata,
  input  logic        lookup2tag_array_valid,
  output logic        fill2tag_array_valid,
  output logic [5:0]  fill2tag_array_index,
  output logic [2:0]  fill2tag_array_way,
  output logic [43:0] fill2tag_array_wdata
);

  typedef enum logic [2:0] {IDLE, REQ, RECV, TAG, DONE} state_t;

  state_t      state;
  logic [63:6] addr_q;
  logic [2:0]  way_q;
  logic [2:0]  rr_q;
  logic [2:0]  beat_q;
  logic        beat_fire;
  logic        unused_addr_bits;

  // Line offset bits never matter: the whole line is fetched.
  assign unused_addr_bits = ^lookup2fill_addr[5:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      way_q  <= 3'd0;
      rr_q   <= 3'd0;
      beat_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (lookup2fill_valid) begin
            addr_q <= lookup2fill_addr[63:6];
            way_q  <= rr_q;
            beat_q <= 3'd0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (mem2fill_req_ready) state <= RECV;
        end
        RECV: begin
          // The last marker ends the burst whatever the count; the counter simply wraps.
          if (mem2fill_resp_valid) begin
            if (mem2fill_resp_last) begin
              beat_q <= 3'd0;
              state  <= TAG;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end
        end
        TAG: begin
          if (!lookup2tag_array_valid) state <= DONE;
        end
        DONE: begin
          rr_q  <= rr_q + 3'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign beat_fire = (state == RECV) && mem2fill_resp_valid;

  assign fill2lookup_ready   = (state == IDLE);
  assign fill2lookup_done    = (state == DONE);
  assign fill2lookup_way     = (state == DONE) ? way_q : 3'd0;

  assign fill2mem_req_valid  = (state == REQ);
  assign fill2mem_req_addr   = {addr_q, 6'b0};
  assign fill2mem_resp_ready = (state == RECV);

  assign fill2data_array_valid  = beat_fire;
  assign fill2data_array_index  = addr_q[11:6];
  assign fill2data_array_way    = way_q;
  assign fill2data_array_offset = beat_q;
  assign fill2data_array_wdata  = beat_fire ? mem2fill_resp_data : 64'd0;

  // Tag write yields to a lookup read of the tag array in the same cycle.
  assign fill2tag_array_valid = (state == TAG) && !lookup2tag_array_valid;
  assign fill2tag_array_index = addr_q[11:6];
  assign fill2tag_array_way   = way_q;
  assign fill2tag_array_wdata = (state == TAG) ? {1'b1, 1'b0, addr_q[53:12]} : 44'd0;

endmodule
